// File: rtl/ctrl_hazard_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_hazard_pkg
//   Types and helpers shared by the control-hazard unit and its counters.
//   - src_e   : redirect source. The encoding order is also the age order:
//               a larger value is an older stage and wins priority.
//   - state_e : redirect FSM states.
//   - flush_mask(): builds the per-stage squash vector for a given source.
// ---------------------------------------------------------------------------
package ctrl_hazard_pkg;

    // Upper bound on pipeline depth handled by flush_mask().
    localparam int MAX_STAGES = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_TRAP = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SHADOW = 2'd2
    } state_e;

    // Squash vector for a redirect from src. A trap also kills the trapping
    // instruction itself, so its mask reaches one stage further than the
    // resolve stage; branches and jumps only kill the younger stages.
    function automatic logic [MAX_STAGES-1:0] flush_mask(
        input src_e src,
        input int   jmp_stage,
        input int   br_stage,
        input int   trap_stage
    );
        int                    n;
        logic [MAX_STAGES-1:0] m;
        case (src)
            SRC_TRAP: n = trap_stage + 1;
            SRC_BR:   n = br_stage;
            SRC_JMP:  n = jmp_stage;
            default:  n = 0;
        endcase
        m = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/control_hazard_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   W-bit event counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk  in  1   clock
//     rst  in  1   synchronous reset, active-high (clears the count)
//     inc  in  1   count one event on this edge
//     cnt  out W   current count
// ---------------------------------------------------------------------------
module sat_counter
    import ctrl_hazard_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/control_hazard_unit.sv
// ---------------------------------------------------------------------------
// control_hazard_unit
//   Arbitrates trap / taken-branch / jump redirects for the pipelined core and
//   drives a registered redirect pulse, redirect PC and per-stage flush vector
//   into IF. A redirect requested while the pipe is stalled is parked in PEND
//   until the stall drops. The cycle after an issue (SHADOW) ignores requests
//   from the issuing stage and younger, since those are wrong-path.
//   Ports:
//     clk, rst         clock / synchronous active-high reset
//     stall_i          pipeline hold; nothing issues while high
//     br_valid_i/br_taken_i/br_target_i   branch in BR_STAGE
//     jmp_valid_i/jmp_target_i            jump in JMP_STAGE
//     trap_valid_i/trap_vector_i          trap in TRAP_STAGE
//     redirect_o       one-cycle pulse: load redirect_pc_o into PC
//     redirect_pc_o    redirect target, holds last value between pulses
//     flush_o          bit i squashes stage i; non-zero only with redirect_o
//     busy_o           a redirect is parked (PEND)
//     br_cnt_o/jmp_cnt_o/trap_cnt_o       saturating issued-redirect counts
// ---------------------------------------------------------------------------
module control_hazard_unit
    import ctrl_hazard_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 5,
    parameter int JMP_STAGE  = 1,
    parameter int BR_STAGE   = 2,
    parameter int TRAP_STAGE = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  br_valid_i,
    input  logic                  br_taken_i,
    input  logic [XLEN-1:0]       br_target_i,
    input  logic                  jmp_valid_i,
    input  logic [XLEN-1:0]       jmp_target_i,
    input  logic                  trap_valid_i,
    input  logic [XLEN-1:0]       trap_vector_i,
    output logic                  redirect_o,
    output logic [XLEN-1:0]       redirect_pc_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      br_cnt_o,
    output logic [CNT_W-1:0]      jmp_cnt_o,
    output logic [CNT_W-1:0]      trap_cnt_o
);

    // ---------------- registered state ----------------
    state_e                  state_q;
    src_e                    last_src_q;   // source issued on the previous edge
    src_e                    pend_src_q;
    logic [XLEN-1:0]         pend_tgt_q;
    logic                    redirect_q;
    logic [XLEN-1:0]         redirect_pc_q;
    logic [NUM_STAGES-1:0]   flush_q;

    // ---------------- next-state / combinational ----------------
    state_e                  state_d;
    src_e                    pend_src_d;
    logic [XLEN-1:0]         pend_tgt_d;
    logic [NUM_STAGES-1:0]   flush_d;

    logic                    br_req;
    src_e                    floor_src;    // sources at or below this are masked
    src_e                    cand_src;
    logic [XLEN-1:0]         cand_tgt;
    src_e                    pend_eff_src;
    logic [XLEN-1:0]         pend_eff_tgt;
    src_e                    issue_src;    // SRC_NONE when nothing issues this edge
    logic [XLEN-1:0]         issue_tgt;
    logic [MAX_STAGES-1:0]   issue_mask;

    always_comb begin
        br_req = br_valid_i & br_taken_i;

        // In SHADOW only strictly older sources than the one just issued may
        // be accepted; elsewhere nothing is masked.
        floor_src = (state_q == SHADOW) ? last_src_q : SRC_NONE;

        // Oldest-stage-first priority encoder over the unmasked requests.
        cand_src = SRC_NONE;
        cand_tgt = jmp_target_i;
        if (trap_valid_i && (SRC_TRAP > floor_src)) begin
            cand_src = SRC_TRAP;
            cand_tgt = trap_vector_i;
        end else if (br_req && (SRC_BR > floor_src)) begin
            cand_src = SRC_BR;
            cand_tgt = br_target_i;
        end else if (jmp_valid_i && (SRC_JMP > floor_src)) begin
            cand_src = SRC_JMP;
            cand_tgt = jmp_target_i;
        end

        // While parked, only a trap can displace the latched redirect. This
        // also applies on the release cycle, so a trap arriving as the stall
        // drops is issued instead of the younger wrong-path redirect.
        pend_eff_src = pend_src_q;
        pend_eff_tgt = pend_tgt_q;
        if (trap_valid_i && (pend_src_q != SRC_TRAP)) begin
            pend_eff_src = SRC_TRAP;
            pend_eff_tgt = trap_vector_i;
        end

        state_d    = IDLE;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        issue_src  = SRC_NONE;
        issue_tgt  = redirect_pc_q;

        case (state_q)
            PEND: begin
                if (stall_i) begin
                    state_d    = PEND;
                    pend_src_d = pend_eff_src;
                    pend_tgt_d = pend_eff_tgt;
                end else begin
                    issue_src = pend_eff_src;
                    issue_tgt = pend_eff_tgt;
                    state_d   = SHADOW;
                end
            end
            default: begin
                // IDLE and SHADOW accept identically once masking is applied.
                if (cand_src != SRC_NONE) begin
                    if (stall_i) begin
                        state_d    = PEND;
                        pend_src_d = cand_src;
                        pend_tgt_d = cand_tgt;
                    end else begin
                        issue_src = cand_src;
                        issue_tgt = cand_tgt;
                        state_d   = SHADOW;
                    end
                end
            end
        endcase

        // flush_mask(SRC_NONE) is all-zero, so flush is quiet without a pulse.
        issue_mask = flush_mask(issue_src, JMP_STAGE, BR_STAGE, TRAP_STAGE);
        flush_d    = issue_mask[NUM_STAGES-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_src_q    <= SRC_NONE;
            pend_src_q    <= SRC_NONE;
            pend_tgt_q    <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_src_q    <= issue_src;
            pend_src_q    <= pend_src_d;
            pend_tgt_q    <= pend_tgt_d;
            redirect_q    <= (issue_src != SRC_NONE);
            redirect_pc_q <= issue_tgt;
            flush_q       <= flush_d;
        end
    end

    // ---------------- event counters: [0]=jmp, [1]=br, [2]=trap ----------------
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    assign cnt_inc = {issue_src == SRC_TRAP, issue_src == SRC_BR, issue_src == SRC_JMP};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            sat_counter #(
                .W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (cnt_inc[gi]),
                .cnt (cnt_val[gi])
            );
        end
    endgenerate

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign flush_o       = flush_q;
    assign busy_o        = (state_q == PEND);
    assign jmp_cnt_o     = cnt_val[0];
    assign br_cnt_o      = cnt_val[1];
    assign trap_cnt_o    = cnt_val[2];

endmodule

// File: tb/tb_control_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_control_hazard_unit
//   Directed scenarios plus a randomized run against a behavioural model.
//   Two instances share the stimulus: dut (CNT_W=16) and dut_s (CNT_W=2) for
//   counter saturation.
// ---------------------------------------------------------------------------
module tb_control_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        br_valid_i, br_taken_i;
    logic [31:0] br_target_i;
    logic        jmp_valid_i;
    logic [31:0] jmp_target_i;
    logic        trap_valid_i;
    logic [31:0] trap_vector_i;

    logic        redirect_o, busy_o;
    logic [31:0] redirect_pc_o;
    logic [4:0]  flush_o;
    logic [15:0] br_cnt_o, jmp_cnt_o, trap_cnt_o;

    logic        s_redirect_o, s_busy_o;
    logic [31:0] s_redirect_pc_o;
    logic [4:0]  s_flush_o;
    logic [1:0]  s_br_cnt_o, s_jmp_cnt_o, s_trap_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_hazard_unit #(
        .XLEN(32), .NUM_STAGES(5), .JMP_STAGE(1), .BR_STAGE(2), .TRAP_STAGE(3), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .jmp_valid_i(jmp_valid_i), .jmp_target_i(jmp_target_i),
        .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
        .busy_o(busy_o), .br_cnt_o(br_cnt_o), .jmp_cnt_o(jmp_cnt_o), .trap_cnt_o(trap_cnt_o)
    );

    control_hazard_unit #(
        .XLEN(32), .NUM_STAGES(5), .JMP_STAGE(1), .BR_STAGE(2), .TRAP_STAGE(3), .CNT_W(2)
    ) dut_s (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .jmp_valid_i(jmp_valid_i), .jmp_target_i(jmp_target_i),
        .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
        .redirect_o(s_redirect_o), .redirect_pc_o(s_redirect_pc_o), .flush_o(s_flush_o),
        .busy_o(s_busy_o), .br_cnt_o(s_br_cnt_o), .jmp_cnt_o(s_jmp_cnt_o), .trap_cnt_o(s_trap_cnt_o)
    );

    // Advance one edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i       = 1'b0;
        br_valid_i    = 1'b0;
        br_taken_i    = 1'b0;
        br_target_i   = 32'h0;
        jmp_valid_i   = 1'b0;
        jmp_target_i  = 32'h0;
        trap_valid_i  = 1'b0;
        trap_vector_i = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'hDEAD_BEE0;
        trap_valid_i = 1'b1; trap_vector_i = 32'h1234_5678;
        tick();
        tick();
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL reset_redirect got %0h expected 0", redirect_o); end
        checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %0h expected 0", redirect_pc_o); end
        checks++; if (flush_o !== 5'b0) begin errors++; $display("FAIL reset_flush got %b expected 00000", flush_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h expected 0", busy_o); end
        checks++; if ({br_cnt_o, jmp_cnt_o, trap_cnt_o} !== 48'h0) begin errors++; $display("FAIL reset_cnt got %0d/%0d/%0d expected 0/0/0", br_cnt_o, jmp_cnt_o, trap_cnt_o); end
        rst = 1'b0;
        clear_inputs();
        $display("txn reset: outputs cleared");
    endtask

    // ------------------------------------------------------------------
    task automatic test_branch();
        do_reset();
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h100;
        tick();
        clear_inputs();
        checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL br_redirect got %0h expected 1", redirect_o); end
        checks++; if (redirect_pc_o !== 32'h100) begin errors++; $display("FAIL br_pc got %0h expected 100", redirect_pc_o); end
        checks++; if (flush_o !== 5'b00011) begin errors++; $display("FAIL br_flush got %b expected 00011", flush_o); end
        checks++; if (br_cnt_o !== 16'd1) begin errors++; $display("FAIL br_cnt got %0d expected 1", br_cnt_o); end
        tick();
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL br_pulse_end got %0h expected 0", redirect_o); end
        checks++; if (redirect_pc_o !== 32'h100) begin errors++; $display("FAIL br_pc_hold got %0h expected 100", redirect_pc_o); end
        checks++; if (flush_o !== 5'b0) begin errors++; $display("FAIL br_flush_end got %b expected 00000", flush_o); end
        // Branch not taken: no redirect.
        br_valid_i = 1'b1; br_taken_i = 1'b0; br_target_i = 32'h200;
        tick();
        clear_inputs();
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL br_not_taken got %0h expected 0", redirect_o); end
        $display("txn branch: target 0x100 issued, not-taken ignored");
    endtask

    // ------------------------------------------------------------------
    task automatic test_jump_stall();
        do_reset();
        jmp_valid_i = 1'b1; jmp_target_i = 32'h40; stall_i = 1'b1;
        tick();
        jmp_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL jmp_busy[%0d] got %0h expected 1", k, busy_o); end
            checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL jmp_early[%0d] got %0h expected 0", k, redirect_o); end
            if (k == 2) stall_i = 1'b0;
            tick();
        end
        checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL jmp_redirect got %0h expected 1", redirect_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL jmp_busy_end got %0h expected 0", busy_o); end
        checks++; if (redirect_pc_o !== 32'h40) begin errors++; $display("FAIL jmp_pc got %0h expected 40", redirect_pc_o); end
        checks++; if (flush_o !== 5'b00001) begin errors++; $display("FAIL jmp_flush got %b expected 00001", flush_o); end
        checks++; if (jmp_cnt_o !== 16'd1) begin errors++; $display("FAIL jmp_cnt got %0d expected 1", jmp_cnt_o); end
        tick();
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL jmp_single_pulse got %0h expected 0", redirect_o); end
        $display("txn jump: deferred 3 cycles then target 0x40 issued");
    endtask

    // ------------------------------------------------------------------
    task automatic test_trap_br();
        do_reset();
        trap_valid_i = 1'b1; trap_vector_i = 32'h80;
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h200;
        tick();
        clear_inputs();
        checks++; if (redirect_pc_o !== 32'h80) begin errors++; $display("FAIL trapbr_pc got %0h expected 80", redirect_pc_o); end
        checks++; if (flush_o !== 5'b01111) begin errors++; $display("FAIL trapbr_flush got %b expected 01111", flush_o); end
        checks++; if (trap_cnt_o !== 16'd1) begin errors++; $display("FAIL trapbr_trap_cnt got %0d expected 1", trap_cnt_o); end
        checks++; if (br_cnt_o !== 16'd0) begin errors++; $display("FAIL trapbr_br_cnt got %0d expected 0", br_cnt_o); end
        tick();
        checks++; if (br_cnt_o !== 16'd0) begin errors++; $display("FAIL trapbr_br_dropped got %0d expected 0", br_cnt_o); end
        $display("txn trap+branch: trap vector 0x80 issued");
    endtask

    // ------------------------------------------------------------------
    task automatic test_shadow();
        do_reset();
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h100;
        tick();
        clear_inputs();
        jmp_valid_i = 1'b1; jmp_target_i = 32'h44;
        tick();
        clear_inputs();
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL shadow_jmp_masked got %0h expected 0", redirect_o); end
        checks++; if (jmp_cnt_o !== 16'd0) begin errors++; $display("FAIL shadow_jmp_cnt got %0d expected 0", jmp_cnt_o); end
        checks++; if (redirect_pc_o !== 32'h100) begin errors++; $display("FAIL shadow_pc_hold got %0h expected 100", redirect_pc_o); end
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h120;
        tick();
        clear_inputs();
        trap_valid_i = 1'b1; trap_vector_i = 32'h80;
        tick();
        clear_inputs();
        checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL shadow_trap_redirect got %0h expected 1", redirect_o); end
        checks++; if (redirect_pc_o !== 32'h80) begin errors++; $display("FAIL shadow_trap_pc got %0h expected 80", redirect_pc_o); end
        checks++; if (flush_o !== 5'b01111) begin errors++; $display("FAIL shadow_trap_flush got %b expected 01111", flush_o); end
        checks++; if ({br_cnt_o, trap_cnt_o} !== {16'd2, 16'd1}) begin errors++; $display("FAIL shadow_cnts got br=%0d trap=%0d expected br=2 trap=1", br_cnt_o, trap_cnt_o); end
        $display("txn shadow: jump masked, trap accepted");
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_pend();
        do_reset();
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h100;
        tick();
        clear_inputs();
        tick();
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h300; stall_i = 1'b1;
        tick();
        br_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstpend_busy got %0h expected 1", busy_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall_i = 1'b0;
        checks++; if ({redirect_o, busy_o, flush_o} !== 7'b0) begin errors++; $display("FAIL rstpend_ctl got %b expected 0000000", {redirect_o, busy_o, flush_o}); end
        checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rstpend_pc got %0h expected 0", redirect_pc_o); end
        checks++; if (br_cnt_o !== 16'd0) begin errors++; $display("FAIL rstpend_cnt got %0d expected 0", br_cnt_o); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL rstpend_dropped[%0d] got %0h expected 0", k, redirect_o); end
        end
        $display("txn reset during pend: redirect dropped");
    endtask

    // ------------------------------------------------------------------
    // A branch held high issues every other cycle (SHADOW masks the repeat).
    task automatic test_back_to_back_saturate();
        do_reset();
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h500;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++; if (redirect_o !== 1'((i % 2) == 1)) begin errors++; $display("FAIL b2b_pulse[%0d] got %0h expected %0h", i, redirect_o, (i % 2)); end
            checks++; if (br_cnt_o !== 16'((i + 1) / 2)) begin errors++; $display("FAIL b2b_cnt[%0d] got %0d expected %0d", i, br_cnt_o, (i + 1) / 2); end
            checks++; if (s_br_cnt_o !== 2'(((i + 1) / 2 > 3) ? 3 : (i + 1) / 2)) begin errors++; $display("FAIL sat_cnt[%0d] got %0d expected %0d", i, s_br_cnt_o, ((i + 1) / 2 > 3) ? 3 : (i + 1) / 2); end
        end
        clear_inputs();
        $display("txn saturate: 5 branches, wide count %0d, 2-bit count %0d", br_cnt_o, s_br_cnt_o);
    endtask

    // ------------------------------------------------------------------
    // Random run against a behavioural model. Sources are ranked by age
    // (1=jmp, 2=br, 3=trap); a request counts only if older than whatever
    // issued on the previous edge.
    task automatic test_random();
        int          m_shadow, m_pend_src, src, best;
        bit          m_pend, issued;
        logic [31:0] m_pend_tgt, tgt, best_tgt;
        logic        e_redirect, e_busy;
        logic [31:0] e_pc;
        logic [4:0]  e_flush;
        int          e_cnt [4];
        int          e_sat [4];

        do_reset();
        m_shadow = 0; m_pend = 0; m_pend_src = 0; m_pend_tgt = 0;
        e_redirect = 0; e_busy = 0; e_pc = 0; e_flush = 0;
        for (int i = 0; i < 4; i++) begin e_cnt[i] = 0; e_sat[i] = 0; end

        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst           = ($urandom_range(99) == 0);
            stall_i       = ($urandom_range(9) < 3);
            br_valid_i    = ($urandom_range(9) < 3);
            br_taken_i    = 1'($urandom_range(1));
            br_target_i   = $urandom;
            jmp_valid_i   = ($urandom_range(9) < 2);
            jmp_target_i  = $urandom;
            trap_valid_i  = ($urandom_range(99) < 8);
            trap_vector_i = $urandom;

            issued = 0; src = 0; tgt = e_pc;
            if (rst) begin
                m_pend = 0; m_shadow = 0;
                e_pc = 0;
                for (int i = 0; i < 4; i++) begin e_cnt[i] = 0; e_sat[i] = 0; end
            end else if (m_pend) begin
                if (trap_valid_i && m_pend_src != 3) begin m_pend_src = 3; m_pend_tgt = trap_vector_i; end
                if (!stall_i) begin issued = 1; src = m_pend_src; tgt = m_pend_tgt; m_pend = 0; end
            end else begin
                best = 0; best_tgt = 0;
                if (jmp_valid_i && 1 > m_shadow) begin best = 1; best_tgt = jmp_target_i; end
                if (br_valid_i && br_taken_i && 2 > m_shadow) begin best = 2; best_tgt = br_target_i; end
                if (trap_valid_i && 3 > m_shadow) begin best = 3; best_tgt = trap_vector_i; end
                if (best != 0) begin
                    if (stall_i) begin m_pend = 1; m_pend_src = best; m_pend_tgt = best_tgt; end
                    else begin issued = 1; src = best; tgt = best_tgt; end
                end
            end
            if (!rst) begin
                m_shadow = issued ? src : 0;
                if (issued) begin
                    e_pc = tgt;
                    e_cnt[src] = e_cnt[src] + 1;
                    if (e_sat[src] < 3) e_sat[src] = e_sat[src] + 1;
                end
            end
            e_redirect = issued;
            e_busy     = m_pend;
            case (src)
                3:       e_flush = 5'((1 << 4) - 1);
                2:       e_flush = 5'((1 << 2) - 1);
                1:       e_flush = 5'((1 << 1) - 1);
                default: e_flush = 5'd0;
            endcase

            tick();

            checks++; if (redirect_o !== e_redirect) begin errors++; $display("FAIL rnd_redirect cyc %0d got %0h expected %0h", cyc, redirect_o, e_redirect); end
            checks++; if (redirect_pc_o !== e_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %0h expected %0h", cyc, redirect_pc_o, e_pc); end
            checks++; if (flush_o !== e_flush) begin errors++; $display("FAIL rnd_flush cyc %0d got %b expected %b", cyc, flush_o, e_flush); end
            checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %0h expected %0h", cyc, busy_o, e_busy); end
            checks++; if ({jmp_cnt_o, br_cnt_o, trap_cnt_o} !== {16'(e_cnt[1]), 16'(e_cnt[2]), 16'(e_cnt[3])}) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d/%0d expected %0d/%0d/%0d", cyc, jmp_cnt_o, br_cnt_o, trap_cnt_o, e_cnt[1], e_cnt[2], e_cnt[3]); end
            checks++; if ({s_jmp_cnt_o, s_br_cnt_o, s_trap_cnt_o} !== {2'(e_sat[1]), 2'(e_sat[2]), 2'(e_sat[3])}) begin errors++; $display("FAIL rnd_sat cyc %0d got %0d/%0d/%0d expected %0d/%0d/%0d", cyc, s_jmp_cnt_o, s_br_cnt_o, s_trap_cnt_o, e_sat[1], e_sat[2], e_sat[3]); end
            if (e_redirect) $display("txn rnd cyc %0d src %0d pc %h", cyc, src, e_pc);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_branch();
        test_jump_stall();
        test_trap_br();
        test_shadow();
        test_reset_pend();
        test_back_to_back_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
